// File: rtl/battleship_pkg.sv
// battleship_pkg: shared grid constants, shot FSM states and seven-segment digit encoding
package battleship_pkg;
  localparam int GRID_SIZE = 5;
  localparam int COORD_W = 3;
  typedef logic [COORD_W-1:0] coord_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {IDLE, PENDING} shot_state_t;
  function automatic logic [6:0] seg7(input coord_t c);
    return c == 3'd0 ? SEG_0 :
           c == 3'd1 ? SEG_1 :
           c == 3'd2 ? SEG_2 :
           c == 3'd3 ? SEG_3 :
           c == 3'd4 ? SEG_4 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/shot_selector_if.sv
// shot_selector_if: shot request valid/ready handshake towards the game FSM
interface shot_selector_if;
  import battleship_pkg::*;
  logic shotValid;
  logic shotReady;
  coord_t shotRow;
  coord_t shotCol;
  modport master (output shotValid, output shotRow, output shotCol, input shotReady);
  modport slave (input shotValid, input shotRow, input shotCol, output shotReady);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchroniser, counter debouncer and one-cycle rising-edge pulse
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rstSwitch,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic stable, stable_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rstSwitch) begin
    if (!rstSwitch) begin
      sync <= '0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      stable_d <= stable;
      pulse <= stable & ~stable_d;
      // any sample matching the stable level restarts the count, so glitches never accumulate
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/shot_selector.sv
// shot_selector: conditions the board buttons, moves the 5x5 cursor and issues one shot per select press
module shot_selector #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int GRID_SIZE = battleship_pkg::GRID_SIZE
) (
  input  logic clk,
  input  logic rstSwitch,
  input  logic rowButton,
  input  logic colButton,
  input  logic selectButton,
  input  logic enable,
  shot_selector_if.master shot,
  output logic [6:0] rowSeg,
  output logic [6:0] colSeg
);
  import battleship_pkg::*;
  logic row_p, col_p, sel_p;
  shot_state_t state_q, state_d;
  coord_t row_q, row_d, col_q, col_d, srow_q, srow_d, scol_q, scol_d;
  function automatic coord_t next_coord(input coord_t c);
    return c == COORD_W'(GRID_SIZE - 1) ? '0 : c + 1'b1;
  endfunction
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_row (.clk, .rstSwitch, .raw(rowButton), .pulse(row_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_col (.clk, .rstSwitch, .raw(colButton), .pulse(col_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (.clk, .rstSwitch, .raw(selectButton), .pulse(sel_p));
  always_ff @(posedge clk or negedge rstSwitch) begin
    if (!rstSwitch) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      srow_q <= '0;
      scol_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      srow_q <= srow_d;
      scol_q <= scol_d;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    srow_d = srow_q;
    scol_d = scol_q;
    if (state_q == IDLE) begin
      // a fire press wins over cursor moves arriving in the same cycle
      if (sel_p && enable) begin
        state_d = PENDING;
        srow_d = row_q;
        scol_d = col_q;
      end else begin
        row_d = row_p ? next_coord(row_q) : row_q;
        col_d = col_p ? next_coord(col_q) : col_q;
      end
    end else state_d = shot.shotReady ? IDLE : PENDING;
  end
  assign shot.shotValid = state_q == PENDING;
  assign shot.shotRow = srow_q;
  assign shot.shotCol = scol_q;
  assign rowSeg = seg7(row_q);
  assign colSeg = seg7(col_q);
endmodule
